mem_port_arbiter_32: RTL and testbench

Single-port memory arbiter for the 32-bit memory system: shares one unified word-addressed memory (text words followed by data words) between the instruction-fetch port and the data load/store port. It translates MIPS byte addresses into physical word indexes and rejects illegal accesses with a fault response. It sequences every transaction through a fixed three-cycle request/ack handshake, with data priority and a fetch anti-starvation counter.

---
 rtl/mem_port_arbiter_32.sv | 124 ++++++++++++
 tb/tb_mem_port_arbiter_32.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_32.sv
// mem_port_arbiter_32: single-port memory arbiter sharing unified text/data memory between fetch and load/store ports.
module mem_port_arbiter_32 #(
    parameter int MEMORY_DEPTH = 64,
    parameter int TEXT_WORDS = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] TEXT_BASE = 32'h0040_0000,
    parameter logic [DATA_WIDTH-1:0] DATA_BASE = 32'h1001_0000,
    parameter int MAX_WAIT = 3
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            IF_Req_i,
    input  logic [DATA_WIDTH-1:0]           IF_Addr_i,
    output logic                            IF_Ack_o,
    output logic [DATA_WIDTH-1:0]           IF_Data_o,
    output logic                            IF_Fault_o,
    input  logic                            D_Req_i,
    input  logic                            D_We_i,
    input  logic [DATA_WIDTH-1:0]           D_Addr_i,
    input  logic [DATA_WIDTH-1:0]           D_WrData_i,
    output logic                            D_Ack_o,
    output logic [DATA_WIDTH-1:0]           D_Data_o,
    output logic                            D_Fault_o,
    output logic [$clog2(MEMORY_DEPTH)-1:0] Mem_Addr_o,
    output logic                            Mem_We_o,
    output logic [DATA_WIDTH-1:0]           Mem_WrData_o,
    input  logic [DATA_WIDTH-1:0]           Mem_RdData_i,
    output logic                            Busy_o
);
    localparam int ADDR_W = $clog2(MEMORY_DEPTH);
    localparam int SW = $clog2(MAX_WAIT + 1);
    localparam logic [DATA_WIDTH-1:0] TEXT_END = TEXT_BASE + DATA_WIDTH'(4 * TEXT_WORDS);
    localparam logic [DATA_WIDTH-1:0] DATA_END = DATA_BASE + DATA_WIDTH'(4 * (MEMORY_DEPTH - TEXT_WORDS));
    localparam logic [SW-1:0] SMAX = SW'(MAX_WAIT);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                state;
    logic [SW-1:0]         starve_cnt;
    logic                  win_d;
    logic                  lat_we;
    logic                  lat_fault;
    logic [ADDR_W-1:0]     lat_idx;
    logic [DATA_WIDTH-1:0] lat_wdata;

    logic                  pick_d;
    logic                  sel_we;
    logic                  text_hit;
    logic                  data_hit;
    logic                  dec_fault;
    logic [DATA_WIDTH-1:0] sel_addr;
    logic [ADDR_W-1:0]     dec_idx;
    logic [SW-1:0]         starve_inc;

    always_comb begin
        pick_d = D_Req_i && !(IF_Req_i && starve_cnt == SMAX);
        sel_addr = pick_d ? D_Addr_i : IF_Addr_i;
        sel_we = pick_d && D_We_i;
        text_hit = sel_addr >= TEXT_BASE && sel_addr < TEXT_END;
        data_hit = sel_addr >= DATA_BASE && sel_addr < DATA_END;
        dec_idx = text_hit ? ADDR_W'((sel_addr - TEXT_BASE) >> 2)
                           : ADDR_W'(TEXT_WORDS) + ADDR_W'((sel_addr - DATA_BASE) >> 2);
        dec_fault = sel_addr[1:0] != 2'b00 || !(text_hit || data_hit) || (sel_we && text_hit);
        starve_inc = starve_cnt == SMAX ? SMAX : starve_cnt + SW'(1);
    end

    // Mem_* are driven straight from the latched request so reset drops the write strobe at once.
    assign Mem_Addr_o = state == ACCESS ? lat_idx : '0;
    assign Mem_We_o = state == ACCESS && lat_we;
    assign Mem_WrData_o = state == ACCESS ? lat_wdata : '0;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state <= IDLE;
            starve_cnt <= '0;
            win_d <= 1'b0;
            lat_we <= 1'b0;
            lat_fault <= 1'b0;
            lat_idx <= '0;
            lat_wdata <= '0;
            IF_Ack_o <= 1'b0;
            IF_Fault_o <= 1'b0;
            IF_Data_o <= '0;
            D_Ack_o <= 1'b0;
            D_Fault_o <= 1'b0;
            D_Data_o <= '0;
            Busy_o <= 1'b0;
        end else begin
            IF_Ack_o <= 1'b0;
            IF_Fault_o <= 1'b0;
            D_Ack_o <= 1'b0;
            D_Fault_o <= 1'b0;
            case (state)
                IDLE: if (IF_Req_i || D_Req_i) begin
                    state <= ACCESS;
                    Busy_o <= 1'b1;
                    win_d <= pick_d;
                    lat_we <= sel_we && !dec_fault;
                    lat_fault <= dec_fault;
                    lat_idx <= dec_fault ? '0 : dec_idx;
                    lat_wdata <= pick_d ? D_WrData_i : '0;
                    starve_cnt <= (IF_Req_i && pick_d) ? starve_inc : '0;
                end
                ACCESS: begin
                    state <= RESP;
                    if (win_d) begin
                        D_Ack_o <= 1'b1;
                        D_Fault_o <= lat_fault;
                        D_Data_o <= (lat_fault || lat_we) ? '0 : Mem_RdData_i;
                    end else begin
                        IF_Ack_o <= 1'b1;
                        IF_Fault_o <= lat_fault;
                        IF_Data_o <= lat_fault ? '0 : Mem_RdData_i;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    Busy_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter_32.sv
// tb_mem_port_arbiter_32: directed and randomized checks of the fetch/data memory arbiter against a behavioural model.
module tb_mem_port_arbiter_32;
    logic        clk = 1'b0;
    logic        reset_i;
    logic        IF_Req_i, D_Req_i, D_We_i;
    logic [31:0] IF_Addr_i, D_Addr_i, D_WrData_i;
    logic        IF_Ack_o, IF_Fault_o, D_Ack_o, D_Fault_o, Mem_We_o, Busy_o;
    logic [31:0] IF_Data_o, D_Data_o, Mem_WrData_o, Mem_RdData_i;
    logic [5:0]  Mem_Addr_o;

    logic [31:0] mem [64];
    logic        pre_we;
    logic [5:0]  pre_a;
    logic [31:0] pre_d;

    logic [31:0] exp_mem [64];
    logic [31:0] exp_if, exp_d;
    int          starve;
    int          vecs, errs;

    always #5 clk = ~clk;

    mem_port_arbiter_32 dut (
        .clk_i(clk), .reset_i(reset_i),
        .IF_Req_i(IF_Req_i), .IF_Addr_i(IF_Addr_i), .IF_Ack_o(IF_Ack_o),
        .IF_Data_o(IF_Data_o), .IF_Fault_o(IF_Fault_o),
        .D_Req_i(D_Req_i), .D_We_i(D_We_i), .D_Addr_i(D_Addr_i), .D_WrData_i(D_WrData_i),
        .D_Ack_o(D_Ack_o), .D_Data_o(D_Data_o), .D_Fault_o(D_Fault_o),
        .Mem_Addr_o(Mem_Addr_o), .Mem_We_o(Mem_We_o), .Mem_WrData_o(Mem_WrData_o),
        .Mem_RdData_i(Mem_RdData_i), .Busy_o(Busy_o)
    );

    always @(posedge clk) begin
        if (pre_we) mem[pre_a] <= pre_d;
        else if (Mem_We_o) mem[Mem_Addr_o] <= Mem_WrData_o;
    end
    assign Mem_RdData_i = mem[Mem_Addr_o];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Address map straight from the memory layout: 32 text words then 32 data words.
    function automatic void ref_decode(input logic [31:0] a, input bit st, output int idx, output bit flt);
        bit txt, dat;
        txt = a >= 32'h0040_0000 && a < 32'h0040_0000 + 32'd128;
        dat = a >= 32'h1001_0000 && a < 32'h1001_0000 + 32'd128;
        idx = txt ? int'((a - 32'h0040_0000) / 4) : dat ? 32 + int'((a - 32'h1001_0000) / 4) : 0;
        flt = (a % 4) != 0 || !(txt || dat) || (st && txt);
        if (flt) idx = 0;
    endfunction

    function automatic logic [31:0] gen_addr();
        int c = $urandom_range(0, 5);
        logic [31:0] k = 32'($urandom_range(0, 31)) * 4;
        logic [31:0] base = ($urandom_range(0, 1) == 1) ? 32'h0040_0000 : 32'h1001_0000;
        if (c <= 1) return 32'h0040_0000 + k;
        if (c <= 3) return 32'h1001_0000 + k;
        if (c == 4) return base + k + 32'($urandom_range(1, 3));
        case ($urandom_range(0, 3))
            0: return 32'h0040_0080 + k;
            1: return 32'h1001_0080 + k;
            2: return base - 32'd4;
            default: return {$urandom} & 32'hFFFF_FFFC;
        endcase
    endfunction

    task automatic txn(input string tag, input bit ifr, input logic [31:0] ifa,
                       input bit dr, input bit dwe, input logic [31:0] da, input logic [31:0] dwd);
        bit wd, st, flt;
        int idx;
        @(negedge clk);
        IF_Req_i = ifr; IF_Addr_i = ifa;
        D_Req_i = dr; D_We_i = dwe; D_Addr_i = da; D_WrData_i = dwd;
        wd = dr && !(ifr && starve == 3);
        st = wd && dwe;
        ref_decode(wd ? da : ifa, st, idx, flt);
        starve = (ifr && wd) ? (starve == 3 ? 3 : starve + 1) : 0;
        @(negedge clk);
        chk({tag, ".busy_acc"}, Busy_o, 1);
        chk({tag, ".mem_addr"}, Mem_Addr_o, idx);
        chk({tag, ".mem_we"}, Mem_We_o, st && !flt);
        if (st && !flt) chk({tag, ".mem_wdata"}, Mem_WrData_o, dwd);
        IF_Addr_i = $urandom; D_Addr_i = $urandom; D_We_i = ~D_We_i; D_WrData_i = $urandom;
        if (st && !flt) exp_mem[idx] = dwd;
        if (wd) exp_d = (flt || st) ? 32'h0 : exp_mem[idx];
        else exp_if = flt ? 32'h0 : exp_mem[idx];
        @(negedge clk);
        chk({tag, ".if_ack"}, IF_Ack_o, !wd);
        chk({tag, ".d_ack"}, D_Ack_o, wd);
        chk({tag, ".if_fault"}, IF_Fault_o, !wd && flt);
        chk({tag, ".d_fault"}, D_Fault_o, wd && flt);
        chk({tag, ".if_data"}, IF_Data_o, exp_if);
        chk({tag, ".d_data"}, D_Data_o, exp_d);
        chk({tag, ".mem_we_resp"}, Mem_We_o, 0);
        IF_Req_i = 1'b0; D_Req_i = 1'b0;
        @(negedge clk);
        chk({tag, ".busy_idle"}, Busy_o, 0);
        chk({tag, ".acks_idle"}, {IF_Ack_o, D_Ack_o}, 0);
    endtask

    initial begin
        bit wd;
        logic [1:0] r;
        vecs = 0; errs = 0; starve = 0; exp_if = 0; exp_d = 0;
        reset_i = 1'b1;
        IF_Req_i = 0; D_Req_i = 0; D_We_i = 0;
        IF_Addr_i = 0; D_Addr_i = 0; D_WrData_i = 0;
        pre_we = 1'b0; pre_a = 0; pre_d = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            pre_we = 1'b1; pre_a = 6'(i);
            pre_d = (i == 0) ? 32'h2008_0005 : $urandom;
            exp_mem[i] = pre_d;
        end
        @(negedge clk);
        pre_we = 1'b0;
        chk("rst.acks", {IF_Ack_o, D_Ack_o, IF_Fault_o, D_Fault_o}, 0);
        chk("rst.busy_we", {Busy_o, Mem_We_o}, 0);
        chk("rst.if_data", IF_Data_o, 0);
        chk("rst.d_data", D_Data_o, 0);
        chk("rst.mem_addr", Mem_Addr_o, 0);
        chk("rst.mem_wdata", Mem_WrData_o, 0);
        reset_i = 1'b0;

        txn("fetch0", 1, 32'h0040_0000, 0, 0, 0, 0);
        txn("store33", 0, 0, 1, 1, 32'h1001_0004, 32'hDEAD_BEEF);
        txn("load33", 0, 0, 1, 0, 32'h1001_0004, 0);
        chk("load33.value", D_Data_o, 32'hDEAD_BEEF);
        txn("flt_st_text", 0, 0, 1, 1, 32'h0040_0008, 32'h1234_5678);
        txn("flt_misalign", 0, 0, 1, 0, 32'h0040_0002, 0);
        txn("flt_range", 0, 0, 1, 0, 32'h0050_0000, 0);
        txn("last_text", 1, 32'h0040_007C, 0, 0, 0, 0);
        txn("last_data", 0, 0, 1, 0, 32'h1001_007C, 0);
        txn("past_text_d", 0, 0, 1, 0, 32'h0040_0080, 0);
        txn("past_text_if", 1, 32'h0040_0080, 0, 0, 0, 0);

        // Both requests held: data wins three times, then fetch is forced through.
        IF_Req_i = 1; IF_Addr_i = 32'h0040_0004;
        D_Req_i = 1; D_We_i = 0; D_Addr_i = 32'h1001_0008;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            wd = (k % 4) != 3;
            starve = wd ? (starve == 3 ? 3 : starve + 1) : 0;
            if (wd) exp_d = exp_mem[34]; else exp_if = exp_mem[1];
            @(negedge clk);
            @(negedge clk);
            chk("starve.d_ack", D_Ack_o, wd);
            chk("starve.if_ack", IF_Ack_o, !wd);
            chk("starve.d_data", D_Data_o, exp_d);
            chk("starve.if_data", IF_Data_o, exp_if);
            @(posedge clk);
        end
        #1;
        IF_Req_i = 0; D_Req_i = 0;

        // Reset lands while a store is in its access cycle.
        @(negedge clk);
        D_Req_i = 1; D_We_i = 1; D_Addr_i = 32'h1001_000C; D_WrData_i = 32'hCAFE_F00D;
        @(negedge clk);
        chk("rstmid.we_before", Mem_We_o, 1);
        reset_i = 1'b1;
        D_Req_i = 0;
        #1;
        chk("rstmid.we_drop", Mem_We_o, 0);
        chk("rstmid.busy", Busy_o, 0);
        @(negedge clk);
        chk("rstmid.no_ack1", {IF_Ack_o, D_Ack_o}, 0);
        @(negedge clk);
        chk("rstmid.no_ack2", {IF_Ack_o, D_Ack_o}, 0);
        chk("rstmid.d_data", D_Data_o, 0);
        reset_i = 1'b0;
        exp_if = 0; exp_d = 0; starve = 0;
        txn("post_rst_fetch", 1, 32'h0040_0000, 0, 0, 0, 0);
        txn("post_rst_load", 0, 0, 1, 0, 32'h1001_000C, 0);

        for (int n = 0; n < 40; n++) begin
            r = 2'($urandom_range(1, 3));
            txn($sformatf("rnd%0d", n), r[0], gen_addr(), r[1], 1'($urandom_range(0, 1)), gen_addr(), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
